// File: rtl/mem_arbiter_pkg.sv
// Shared types for the LC-3b physical-memory arbiter.
//   lc3b_word       16-bit address / counter word
//   lc3b_cacheline  128-bit cache line
//   arb_state_t     arbiter FSM state
//   arb_side_t      which cache owns (or last owned) the memory port
// sat_inc is the saturating increment used by all performance counters.
package mem_arbiter_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_cacheline;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_SERVE_I = 2'd1,
    ARB_SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    ARB_I = 1'b0,
    ARB_D = 1'b1
  } arb_side_t;

  localparam lc3b_word SAT_MAX = 16'hFFFF;

  function automatic lc3b_word sat_inc(input lc3b_word value);
    return (value == SAT_MAX) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the three memory-side links of the arbiter: the I-cache port,
// the D-cache port and the physical-memory port.
//
// Handshake: a cache holds its read/write request level-high until it sees
// its *_pmem_resp pulse for exactly one cycle, and must drop the request in
// the cycle after that pulse. The physical memory sees pmem_read/pmem_write
// held high for the whole transaction and answers with a one-cycle pmem_resp.
// rdata on either cache port is only meaningful in the cycle its resp is high.
//
// Modports:
//   slave  - the arbiter's view (receives cache requests, drives memory)
//   master - the environment's view (caches + physical memory model)
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  // I-cache side
  logic          i_pmem_read;
  lc3b_word      i_pmem_address;
  lc3b_cacheline i_pmem_rdata;
  logic          i_pmem_resp;

  // D-cache side
  logic          d_pmem_read;
  logic          d_pmem_write;
  lc3b_word      d_pmem_address;
  lc3b_cacheline d_pmem_wdata;
  lc3b_cacheline d_pmem_rdata;
  logic          d_pmem_resp;

  // Physical memory side
  logic          pmem_read;
  logic          pmem_write;
  lc3b_word      pmem_address;
  lc3b_cacheline pmem_wdata;
  lc3b_cacheline pmem_rdata;
  logic          pmem_resp;

  modport slave (
    input  i_pmem_read, i_pmem_address,
    output i_pmem_rdata, i_pmem_resp,
    input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    output d_pmem_rdata, d_pmem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output i_pmem_read, i_pmem_address,
    input  i_pmem_rdata, i_pmem_resp,
    output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    input  d_pmem_rdata, d_pmem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );

endinterface

// File: rtl/mem_arbiter_units.sv
// Small storage building blocks used by mem_arbiter.
//
// register     - WIDTH-bit load-enable register with asynchronous clear.
//   clk, rst (async, active-high), load, d -> q
// sat_counter  - 16-bit counter that increments when inc is high and sticks
//                at 16'hFFFF; rst clears it asynchronously.
//   clk, rst (async, active-high), inc -> count

module register #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

module sat_counter
  import mem_arbiter_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     inc,
  output lc3b_word count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one physical-memory port between the LC-3b I-cache and
// D-cache, one cache-line transaction at a time.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-high
//   bus            mem_arbiter_if.slave (I-cache, D-cache and memory links)
//   grant_count_i  saturating count of grants to the I-cache
//   grant_count_d  saturating count of grants to the D-cache
//   wait_count     saturating count of cycles in which some request is
//                  pending while its side is not the one being served
//   state_dbg      current FSM state, for debug / checkers
//
// The winner's command is captured at the IDLE->SERVE edge, so requesters
// may change or drop their inputs mid-transaction without disturbing memory.
// On contention the side opposite last_grant wins; last_grant resets to I,
// so the first contention goes to D.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  mem_arbiter_if.slave       bus,
  output lc3b_word           grant_count_i,
  output lc3b_word           grant_count_d,
  output lc3b_word           wait_count,
  output arb_state_t         state_dbg
);

  arb_state_t    state;
  arb_side_t     last_grant;

  logic          i_req;
  logic          d_req;
  logic          grant_i;
  logic          grant_d;
  logic          grant_any;
  logic          wait_inc;

  lc3b_word      next_addr;
  lc3b_cacheline next_wdata;
  logic          next_rd;
  logic          next_wr;

  lc3b_word      cmd_addr;
  lc3b_cacheline cmd_wdata;
  logic          cmd_rd;
  logic          cmd_wr;

  logic          serving;

  // ---------------------------------------------------------------------------
  // Request decode and arbitration (only acts while IDLE)
  // ---------------------------------------------------------------------------
  assign i_req = bus.i_pmem_read;
  assign d_req = bus.d_pmem_read | bus.d_pmem_write;

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == ARB_IDLE) begin
      if (i_req && d_req) begin
        grant_d = (last_grant == ARB_I);
        grant_i = (last_grant == ARB_D);
      end else begin
        grant_i = i_req;
        grant_d = d_req;
      end
    end
  end

  assign grant_any = grant_i | grant_d;

  // Command to capture. An I grant is always a plain line read. For D,
  // a simultaneous read+write is treated as a writeback.
  always_comb begin
    next_addr  = bus.i_pmem_address;
    next_wdata = '0;
    next_rd    = 1'b1;
    next_wr    = 1'b0;
    if (grant_d) begin
      next_addr  = bus.d_pmem_address;
      next_wdata = bus.d_pmem_wdata;
      next_rd    = bus.d_pmem_read & ~bus.d_pmem_write;
      next_wr    = bus.d_pmem_write;
    end
  end

  // ---------------------------------------------------------------------------
  // Command latches
  // ---------------------------------------------------------------------------
  register #(.WIDTH(16)) u_cmd_addr (
    .clk  (clk),
    .rst  (reset),
    .load (grant_any),
    .d    (next_addr),
    .q    (cmd_addr)
  );

  register #(.WIDTH(128)) u_cmd_wdata (
    .clk  (clk),
    .rst  (reset),
    .load (grant_any),
    .d    (next_wdata),
    .q    (cmd_wdata)
  );

  register #(.WIDTH(1)) u_cmd_rd (
    .clk  (clk),
    .rst  (reset),
    .load (grant_any),
    .d    (next_rd),
    .q    (cmd_rd)
  );

  register #(.WIDTH(1)) u_cmd_wr (
    .clk  (clk),
    .rst  (reset),
    .load (grant_any),
    .d    (next_wr),
    .q    (cmd_wr)
  );

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ARB_IDLE;
      last_grant <= ARB_I;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant_d) begin
            state      <= ARB_SERVE_D;
            last_grant <= ARB_D;
          end else if (grant_i) begin
            state      <= ARB_SERVE_I;
            last_grant <= ARB_I;
          end
        end
        ARB_SERVE_I,
        ARB_SERVE_D: begin
          if (bus.pmem_resp) begin
            state <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign state_dbg = state;

  // ---------------------------------------------------------------------------
  // Memory command and response routing
  // ---------------------------------------------------------------------------
  // The latched op bits keep their value after a transaction ends, so the
  // strobes are gated by state; reset clears state asynchronously, which
  // withdraws the command in the same instant.
  assign serving = (state == ARB_SERVE_I) || (state == ARB_SERVE_D);

  assign bus.pmem_read    = serving & cmd_rd;
  assign bus.pmem_write   = serving & cmd_wr;
  assign bus.pmem_address = cmd_addr;
  assign bus.pmem_wdata   = cmd_wdata;

  assign bus.i_pmem_resp  = (state == ARB_SERVE_I) & bus.pmem_resp;
  assign bus.d_pmem_resp  = (state == ARB_SERVE_D) & bus.pmem_resp;

  // Data fans out unqualified; each cache samples it only on its resp.
  assign bus.i_pmem_rdata = bus.pmem_rdata;
  assign bus.d_pmem_rdata = bus.pmem_rdata;

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
  // A request is waiting whenever its side is not the one in service,
  // including the IDLE cycle in which it is being arbitrated.
  assign wait_inc = (i_req && (state != ARB_SERVE_I)) ||
                    (d_req && (state != ARB_SERVE_D));

  sat_counter u_grant_cnt_i (
    .clk   (clk),
    .rst   (reset),
    .inc   (grant_i),
    .count (grant_count_i)
  );

  sat_counter u_grant_cnt_d (
    .clk   (clk),
    .rst   (reset),
    .inc   (grant_d),
    .count (grant_count_d)
  );

  sat_counter u_wait_cnt (
    .clk   (clk),
    .rst   (reset),
    .inc   (wait_inc),
    .count (wait_count)
  );

endmodule
